// File: rtl/rv_alu_arb_if.sv
// rv_alu_arb_if: requester operation bus and registered response slot of the shared ALU arbiter.
interface rv_alu_arb_if #(parameter int NREQ = 2);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_ctrl;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;
    logic               rsp_err;
    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/rv_alu_arb.sv
// rv_alu_arb: round-robin sharing of one combinational ALU among NREQ requesters,
// with a single registered response slot tagged by the winner's index.
module rv_alu_arb #(
    parameter int NREQ = 2
) (
    input logic        clk_i,
    input logic        rst_ni,
    rv_alu_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [31:0]    a_arr [NREQ];
    logic [31:0]    b_arr [NREQ];
    logic [3:0]     c_arr [NREQ];
    logic [IDW-1:0] ptr, g;
    logic [31:0]    a, b, res;
    logic [3:0]     ctrl;
    logic           accept, fire, bad;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[32*i +: 32];
        assign b_arr[i] = bus.req_b[32*i +: 32];
        assign c_arr[i] = bus.req_ctrl[4*i +: 4];
    end

    // Scan backwards so the last hit is the first valid index at or after ptr, wrapping mod NREQ.
    always_comb begin
        g = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req_valid[IDW'((int'(ptr) + k) % NREQ)]) g = IDW'((int'(ptr) + k) % NREQ);
    end

    assign accept        = !bus.rsp_valid || bus.rsp_ready;
    assign fire          = accept && |bus.req_valid;
    assign bus.req_ready = fire ? NREQ'(1) << g : '0;
    assign a             = a_arr[g];
    assign b             = b_arr[g];
    assign ctrl          = c_arr[g];
    assign bad           = ctrl > 4'd9;

    always_comb begin
        res = 32'h0;
        case (ctrl)
            4'd0: res = a - b;
            4'd1: res = a + b;
            4'd2: res = a << b[4:0];
            4'd3: res = {31'b0, $signed(a) < $signed(b)};
            4'd4: res = {31'b0, a < b};
            4'd5: res = a ^ b;
            4'd6: res = $signed(a) >>> b[4:0];
            4'd7: res = a >> b[4:0];
            4'd8: res = a | b;
            4'd9: res = a & b;
            default: res = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= 32'h0;
            bus.rsp_err    <= 1'b0;
            ptr            <= '0;
        end else if (fire) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_id     <= g;
            bus.rsp_result <= res;
            bus.rsp_err    <= bad;
            ptr            <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv_alu_arb.sv
// tb_rv_alu_arb: directed scoreboard bench for the round-robin ALU arbiter with three requesters.
module tb_rv_alu_arb;
    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  valid = '0;
    logic        rready = 1'b1;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [3:0]  c [3];
    rsp_t        sb [$];
    rsp_t        last;
    int          checks = 0;
    int          errors = 0;

    rv_alu_arb_if #(.NREQ(3)) bus ();
    rv_alu_arb #(.NREQ(3)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    assign bus.req_valid = valid;
    assign bus.req_a     = {a[2], a[1], a[0]};
    assign bus.req_b     = {b[2], b[1], b[0]};
    assign bus.req_ctrl  = {c[2], c[1], c[0]};
    assign bus.rsp_ready = rready;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        logic [4:0] s;
        s = y[4:0];
        case (op)
            4'd0: return x - y;
            4'd1: return x + y;
            4'd2: return x << s;
            4'd3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd4: return (x < y) ? 32'd1 : 32'd0;
            4'd5: return x ^ y;
            4'd6: return $signed(x) >>> s;
            4'd7: return x >> s;
            4'd8: return x | y;
            4'd9: return x & y;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set(input int i, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        a[i] = x;
        b[i] = y;
        c[i] = op;
    endtask

    task automatic check_rsp(input string tag, input logic exp_valid);
        chk({tag, ".valid"}, {31'b0, bus.rsp_valid}, {31'b0, exp_valid});
        chk({tag, ".id"}, {30'b0, bus.rsp_id}, {30'b0, last.id});
        chk({tag, ".result"}, bus.rsp_result, last.res);
        chk({tag, ".err"}, {31'b0, bus.rsp_err}, {31'b0, last.err});
    endtask

    // One clock: check grant before the edge, push the expected response, compare after the edge.
    task automatic tick(input string tag, input logic [2:0] exp_ready, input int g, input logic exp_valid);
        rsp_t e;
        #1;
        chk({tag, ".ready"}, {29'b0, bus.req_ready}, {29'b0, exp_ready});
        if (g >= 0) begin
            e.id  = 2'(g);
            e.res = alu(a[g], b[g], c[g]);
            e.err = c[g] > 4'd9;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g >= 0) last = sb.pop_front();
        check_rsp(tag, exp_valid);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set(i, 32'h0, 32'h0, 4'd1);
        last = '{id: 2'd0, res: 32'h0, err: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        check_rsp("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle", 3'b000, -1, 1'b0);

        set(0, 32'd5, 32'd7, 4'd1);
        valid = 3'b001;
        tick("add0", 3'b001, 0, 1'b1);
        valid = 3'b000;
        tick("drain", 3'b000, -1, 1'b0);

        for (int i = 0; i < 3; i++) set(i, 32'd10 * (i + 1), 32'd3, 4'd1);
        valid = 3'b111;
        tick("rr1", 3'b010, 1, 1'b1);
        tick("rr2", 3'b100, 2, 1'b1);
        tick("rr0", 3'b001, 0, 1'b1);
        tick("rr1b", 3'b010, 1, 1'b1);
        tick("rr2b", 3'b100, 2, 1'b1);
        tick("rr0b", 3'b001, 0, 1'b1);

        set(1, 32'd3, 32'd5, 4'd0);
        set(2, 32'd100, 32'd1, 4'd0);
        valid = 3'b010;
        tick("sub1", 3'b010, 1, 1'b1);
        chk("sub1.value", bus.rsp_result, 32'hFFFFFFFE);
        rready = 1'b0;
        valid = 3'b111;
        for (int i = 0; i < 4; i++) tick("stall", 3'b000, -1, 1'b1);
        rready = 1'b1;
        tick("release", 3'b100, 2, 1'b1);
        valid = 3'b000;
        tick("drain2", 3'b000, -1, 1'b0);

        set(0, 32'hFFFFFFFF, 32'd1, 4'd3);
        valid = 3'b001;
        tick("slt", 3'b001, 0, 1'b1);
        chk("slt.value", bus.rsp_result, 32'd1);
        set(1, 32'hFFFFFFFF, 32'd1, 4'd4);
        valid = 3'b010;
        tick("sltu", 3'b010, 1, 1'b1);
        chk("sltu.value", bus.rsp_result, 32'd0);
        set(2, 32'h80000000, 32'd36, 4'd6);
        valid = 3'b100;
        tick("sra", 3'b100, 2, 1'b1);
        chk("sra.value", bus.rsp_result, 32'hF8000000);

        set(0, 32'h1234, 32'h5678, 4'b1100);
        valid = 3'b001;
        tick("illegal", 3'b001, 0, 1'b1);
        chk("illegal.value", bus.rsp_result, 32'h0);
        chk("illegal.err", {31'b0, bus.rsp_err}, 32'd1);
        set(1, 32'hF0F0, 32'hFFFF, 4'd5);
        valid = 3'b010;
        tick("xor", 3'b010, 1, 1'b1);
        chk("xor.value", bus.rsp_result, 32'h0F0F);
        set(2, 32'd1, 32'd33, 4'd2);
        valid = 3'b100;
        tick("sll", 3'b100, 2, 1'b1);
        set(0, 32'h80000000, 32'd4, 4'd7);
        valid = 3'b001;
        tick("srl", 3'b001, 0, 1'b1);
        set(1, 32'hF0, 32'h0F, 4'd8);
        valid = 3'b010;
        tick("or", 3'b010, 1, 1'b1);
        set(2, 32'hFF, 32'h0F, 4'd9);
        valid = 3'b100;
        tick("and", 3'b100, 2, 1'b1);
        set(0, 32'hFF, 32'h0F, 4'b1010);
        valid = 3'b001;
        tick("ctrl10", 3'b001, 0, 1'b1);

        set(1, 32'd9, 32'd4, 4'd0);
        valid = 3'b010;
        tick("pre_rst", 3'b010, 1, 1'b1);
        rready = 1'b0;
        valid = 3'b111;
        tick("hold_rst", 3'b000, -1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        last = '{id: 2'd0, res: 32'h0, err: 1'b0};
        check_rsp("async_rst", 1'b0);
        chk("async_rst.ready", {29'b0, bus.req_ready}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        rready = 1'b1;
        valid = 3'b110;
        sb.delete();
        tick("post_rst", 3'b010, 1, 1'b1);
        valid = 3'b000;
        tick("final_drain", 3'b000, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
